// File: rtl/i2s_receiver_if.sv
// Sample-pair stream between the I2S receiver and the audio datapath.
// Valid/ready handshake; the pair is held while valid && !ready.
interface i2s_receiver_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic signed [SAMPLE_WIDTH-1:0] sample_left;
  logic signed [SAMPLE_WIDTH-1:0] sample_right;
  logic                           sample_valid;
  logic                           sample_ready;

  modport master (
    output sample_left,
    output sample_right,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_left,
    input  sample_right,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_receiver.sv
// Philips-format I2S deserializer: BCLK-edge-qualified serial capture
// into left/right pairs presented on a valid/ready stream.
module i2s_receiver #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           bclk_rise,
  input  logic           lrclk,
  input  logic           sdata,
  i2s_receiver_if.master out,
  output logic           overflow,
  output logic           frame_error
);
  localparam int CW = $clog2(SLOT_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(SLOT_WIDTH - 1);
  localparam logic [CW-1:0] SWC  = CW'(SAMPLE_WIDTH);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  state_t                  state, state_d;
  logic [CW-1:0]           bit_cnt, cnt_d;
  logic [SAMPLE_WIDTH-1:0] shreg, shreg_d;
  logic [SAMPLE_WIDTH-1:0] left_hold, hold_d;
  logic                    lrclk_q, lrq_d;
  logic                    fe_d, commit, load, ovf_d, lr_edge;

  assign lr_edge = lrclk != lrclk_q;
  assign load    = commit && (!out.sample_valid || out.sample_ready);
  assign ovf_d   = commit && out.sample_valid && !out.sample_ready;

  always_comb begin
    state_d = state;
    cnt_d   = bit_cnt;
    shreg_d = shreg;
    hold_d  = left_hold;
    lrq_d   = lrclk_q;
    fe_d    = 1'b0;
    commit  = 1'b0;
    if (bclk_rise) begin
      lrq_d = lrclk;
      unique case (state)
        SYNC: begin
          if (lrclk_q && !lrclk) begin
            state_d = LEFT;
            cnt_d   = '0;
            shreg_d = '0;
          end
        end
        LEFT, RIGHT: begin
          if (lr_edge) begin
            // edge bit carries the previous LSB slot; never captured
            cnt_d   = '0;
            shreg_d = '0;
            fe_d    = bit_cnt < SWC;
            if (state == LEFT) begin
              hold_d  = shreg;
              state_d = RIGHT;
            end else begin
              commit  = 1'b1;
              state_d = LEFT;
            end
          end else if (bit_cnt == LAST) begin
            fe_d    = 1'b1;
            cnt_d   = '0;
            shreg_d = '0;
            state_d = SYNC;
          end else begin
            cnt_d = bit_cnt + 1'b1;
            if (bit_cnt < SWC)
              shreg_d = shreg |
                ({sdata, {(SAMPLE_WIDTH-1){1'b0}}} >> bit_cnt);
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= SYNC;
      bit_cnt          <= '0;
      shreg            <= '0;
      left_hold        <= '0;
      lrclk_q          <= 1'b0;
      out.sample_left  <= '0;
      out.sample_right <= '0;
      out.sample_valid <= 1'b0;
      overflow         <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= cnt_d;
      shreg       <= shreg_d;
      left_hold   <= hold_d;
      lrclk_q     <= lrq_d;
      overflow    <= ovf_d;
      frame_error <= fe_d;
      if (load) begin
        out.sample_left  <= left_hold;
        out.sample_right <= shreg;
        out.sample_valid <= 1'b1;
      end else if (out.sample_valid && out.sample_ready) begin
        out.sample_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_receiver.sv
// Directed I2S frames with a queue scoreboard and a decoupled
// negedge monitor for the sample-pair stream.
module tb_i2s_receiver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bclk_rise = 1'b0;
  logic lrclk = 1'b0;
  logic sdata = 1'b0;
  logic overflow, frame_error;

  int cmp = 0;
  int mism = 0;
  int ovf_cnt = 0;
  int fe_cnt = 0;
  int edge_n = 0;
  int last_rise = -10;

  logic [47:0] exp_q[$];

  i2s_receiver_if #(.SAMPLE_WIDTH(24)) bus ();

  i2s_receiver #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bclk_rise  (bclk_rise),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .out        (bus.master),
    .overflow   (overflow),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    edge_n++;
    if (bclk_rise) last_rise = edge_n;
  end

  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [23:0] pl = '0;
  logic [23:0] prr = '0;

  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
    if (frame_error) fe_cnt++;
    if (!reset) begin
      if (bus.sample_valid && !pv)
        chk("latency", 64'(last_rise), 64'(edge_n));
      if (pv && !pr) begin
        chk("hold_valid", 64'(bus.sample_valid), 64'd1);
        chk("hold_data", {16'd0, bus.sample_left, bus.sample_right},
            {16'd0, pl, prr});
      end
      if (bus.sample_valid && bus.sample_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pair", {16'd0, bus.sample_left,
              bus.sample_right}, 64'd0);
        end else begin
          chk("pair", {16'd0, bus.sample_left, bus.sample_right},
              {16'd0, exp_q.pop_front()});
        end
      end
    end
    pv  = bus.sample_valid && !reset;
    pr  = bus.sample_ready;
    pl  = bus.sample_left;
    prr = bus.sample_right;
  end

  task automatic send_bit(input logic lr, input logic d);
    @(posedge clk);
    #1;
    bclk_rise = 1'b1;
    lrclk = lr;
    sdata = d;
    @(posedge clk);
    #1;
    bclk_rise = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic slot(input logic lr, input logic [23:0] w,
                      input int nbits, input int len);
    logic d;
    for (int i = 0; i < len; i++) begin
      if (i == 0 || i > nbits) d = 1'b1;
      else d = w[24-i];
      send_bit(lr, d);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    exp_q.push_back({l, r});
  endtask

  task automatic drain(input string name);
    repeat (20) @(posedge clk);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  int f0, o0;

  initial begin
    #200_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, mism + 1);
    $fatal(1);
  end

  initial begin
    bus.sample_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.sample_valid), 64'd0);
    chk("rst_left", 64'(bus.sample_left), 64'd0);
    chk("rst_right", 64'(bus.sample_right), 64'd0);
    chk("rst_flags", {62'd0, overflow, frame_error}, 64'd0);
    #1;
    reset = 1'b0;

    // basic frame
    f0 = fe_cnt; o0 = ovf_cnt;
    slot(1, 24'h0, 24, 32);
    slot(0, 24'h123456, 24, 32);
    slot(1, 24'hABCDEF, 24, 32);
    push(24'h123456, 24'hABCDEF);
    slot(0, 24'h0, 24, 2);
    drain("t1_drain");
    chk("t1_fe", 64'(fe_cnt - f0), 64'd0);
    chk("t1_ovf", 64'(ovf_cnt - o0), 64'd0);

    // start mid right slot
    do_reset();
    f0 = fe_cnt;
    slot(1, 24'hFFFFFF, 24, 20);
    slot(0, 24'h5A5A5A, 24, 32);
    slot(1, 24'h0F0F0F, 24, 32);
    push(24'h5A5A5A, 24'h0F0F0F);
    slot(0, 24'h0, 24, 2);
    drain("t2_drain");
    chk("t2_fe", 64'(fe_cnt - f0), 64'd0);

    // backpressure and overflow
    do_reset();
    o0 = ovf_cnt;
    bus.sample_ready = 1'b0;
    slot(1, 24'h0, 24, 32);
    slot(0, 24'h111111, 24, 32);
    slot(1, 24'h222222, 24, 32);
    push(24'h111111, 24'h222222);
    slot(0, 24'h333333, 24, 32);
    slot(1, 24'h444444, 24, 32);
    slot(0, 24'h555555, 24, 32);
    slot(1, 24'h666666, 24, 32);
    slot(0, 24'h0, 24, 2);
    repeat (4) @(posedge clk);
    chk("t3_ovf", 64'(ovf_cnt - o0), 64'd2);
    chk("t3_pending", 64'(exp_q.size()), 64'd1);
    #1;
    bus.sample_ready = 1'b1;
    drain("t3_drain");

    // short 16-BCLK slots
    do_reset();
    f0 = fe_cnt;
    slot(1, 24'h0, 24, 16);
    slot(0, 24'h800200, 15, 16);
    slot(1, 24'h7FFE00, 15, 16);
    push(24'h800200, 24'h7FFE00);
    slot(0, 24'h0, 24, 2);
    drain("t4_drain");
    chk("t4_fe", 64'(fe_cnt - f0), 64'd2);

    // LRCLK stuck low: error on the 33rd BCLK of the slot
    do_reset();
    slot(1, 24'h0, 24, 32);
    slot(0, 24'h010203, 24, 32);
    slot(1, 24'h040506, 24, 32);
    push(24'h010203, 24'h040506);
    f0 = fe_cnt;
    slot(0, 24'h0, 24, 32);
    repeat (2) @(posedge clk);
    chk("t5_fe_before", 64'(fe_cnt - f0), 64'd0);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1);
    chk("t5_fe_after", 64'(fe_cnt - f0), 64'd1);
    slot(1, 24'h0, 24, 32);
    slot(0, 24'h7FFFFF, 24, 32);
    slot(1, 24'h800000, 24, 32);
    push(24'h7FFFFF, 24'h800000);
    slot(0, 24'h0, 24, 2);
    drain("t5_drain");
    chk("t5_fe_total", 64'(fe_cnt - f0), 64'd1);

    // reset mid-left word
    do_reset();
    slot(1, 24'h0, 24, 32);
    slot(0, 24'h13579B, 24, 32);
    slot(1, 24'h2468AC, 24, 32);
    push(24'h13579B, 24'h2468AC);
    slot(0, 24'hFEDCBA, 24, 10);
    chk("t6_pre_left", 64'(bus.sample_left), 64'h13579B);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_left", 64'(bus.sample_left), 64'd0);
    chk("t6_right", 64'(bus.sample_right), 64'd0);
    chk("t6_valid", 64'(bus.sample_valid), 64'd0);
    chk("t6_flags", {62'd0, overflow, frame_error}, 64'd0);
    f0 = fe_cnt;
    slot(1, 24'h0, 24, 32);
    slot(0, 24'h0A0B0C, 24, 32);
    slot(1, 24'h0D0E0F, 24, 32);
    push(24'h0A0B0C, 24'h0D0E0F);
    slot(0, 24'h0, 24, 2);
    drain("t6_drain");
    chk("t6_fe", 64'(fe_cnt - f0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
